// File: rtl/pattern_sequencer.sv
// pattern_sequencer: run controller for the 7-seg fidget patterns.
// Turns debounced button pulses into run/pause/speed control and produces
// the step tick, the active pattern index and a one-cycle pattern reset on
// every pattern switch.
// Optional feature: define AUTO_CYCLE_EN to auto-advance to the next pattern
// after LAPS completed laps (pat_done pulses) of the current one.
module pattern_sequencer #(
    parameter int  NUM_PATTERNS = 4,
    parameter int  DIV_BASE     = 3_125_000,
    parameter int  INIT_SPEED   = 2,
    parameter int  LAPS         = 3,
    localparam int SW           = $clog2(NUM_PATTERNS)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          btn_next,
    input  logic          btn_pause,
    input  logic          btn_speed,
    input  logic          pat_done,
    output logic          step_en,
    output logic [SW-1:0] pat_sel,
    output logic          pat_rst,
    output logic [1:0]    speed,
    output logic          blank,
    output logic          running
);

    // Prescaler is sized for the slowest speed (DIV_BASE << 3).
    localparam int              PW        = $clog2(DIV_BASE * 8);
    localparam logic [PW-1:0]   TERM0     = PW'(DIV_BASE - 1);
    localparam logic [PW-1:0]   TERM1     = PW'(DIV_BASE * 2 - 1);
    localparam logic [PW-1:0]   TERM2     = PW'(DIV_BASE * 4 - 1);
    localparam logic [PW-1:0]   TERM3     = PW'(DIV_BASE * 8 - 1);
    localparam logic [SW-1:0]   LAST_SEL  = SW'(NUM_PATTERNS - 1);
    localparam logic [1:0]      SPEED_RST = 2'(INIT_SPEED);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_PAUSE
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [1:0]    speed_q, speed_d;
    logic [PW-1:0] pres_q, pres_d;
    logic          step_q, step_d;
    logic          pat_rst_q, blank_q, running_q;
    logic [PW-1:0] term;
    logic [SW-1:0] sel_next;
    logic          auto_adv;
    logic          advance;

`ifdef AUTO_CYCLE_EN
    localparam int LW = $clog2(LAPS + 1);
    logic [LW-1:0] lap_q, lap_d;

    // The final lap behaves exactly like a btn_next press from RUN.
    assign auto_adv = (state_q == S_RUN) && pat_done && (lap_q == LW'(LAPS - 1));

    // Lap count: advances on pat_done in RUN, holds in PAUSE, clears on any switch.
    always_comb begin
        lap_d = lap_q;
        if (state_d == S_LOAD) begin
            lap_d = '0;
        end else if ((state_q == S_RUN) && pat_done) begin
            lap_d = lap_q + LW'(1);
        end
    end

    // Lap counter register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            lap_q <= '0;
        end else begin
            lap_q <= lap_d;
        end
    end
`else
    logic unused_pat_done;

    assign auto_adv        = 1'b0;
    assign unused_pat_done = pat_done & (LAPS > 0);
`endif

    // Terminal count of the prescaler for the current speed level.
    always_comb begin
        case (speed_q)
            2'd0:    term = TERM0;
            2'd1:    term = TERM1;
            2'd2:    term = TERM2;
            default: term = TERM3;
        endcase
    end

    assign sel_next = (sel_q == LAST_SEL) ? '0 : sel_q + SW'(1);
    assign advance  = btn_next || auto_adv;

    // Next-state, pattern index, speed and prescaler; buttons resolved by priority.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path infers a latch.
        state_d = state_q;
        sel_d   = sel_q;
        speed_d = speed_q;
        pres_d  = pres_q;
        step_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (btn_next || btn_pause) begin
                    state_d = S_LOAD;
                end else if (btn_speed) begin
                    speed_d = speed_q + 2'd1;
                    pres_d  = '0;
                end
            end
            S_LOAD: begin
                // LOAD is the prescaler's count-0 cycle, so the first tick
                // lands DIV_BASE<<speed cycles after it.
                state_d = S_RUN;
                pres_d  = pres_q + PW'(1);
            end
            S_RUN: begin
                if (advance) begin
                    state_d = S_LOAD;
                    sel_d   = sel_next;
                end else begin
                    if (btn_pause) begin
                        state_d = S_PAUSE;
                    end
                    if (btn_speed) begin
                        speed_d = speed_q + 2'd1;
                        pres_d  = '0;
                    end else if (pres_q == term) begin
                        // Pausing on the terminal count holds it, so the tick
                        // is issued right after resume instead of being lost.
                        if (!btn_pause) begin
                            pres_d = '0;
                            step_d = 1'b1;
                        end
                    end else begin
                        pres_d = pres_q + PW'(1);
                    end
                end
            end
            S_PAUSE: begin
                if (btn_next) begin
                    state_d = S_LOAD;
                    sel_d   = sel_next;
                end else begin
                    if (btn_pause) begin
                        state_d = S_RUN;
                    end
                    if (btn_speed) begin
                        speed_d = speed_q + 2'd1;
                        pres_d  = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_LOAD) begin
            pres_d = '0;
        end
    end

    // State and registered outputs; outputs are decoded from the next state.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!RST_N) begin
            state_q   <= S_IDLE;
            sel_q     <= '0;
            speed_q   <= SPEED_RST;
            pres_q    <= '0;
            step_q    <= 1'b0;
            pat_rst_q <= 1'b0;
            blank_q   <= 1'b1;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            speed_q   <= speed_d;
            pres_q    <= pres_d;
            step_q    <= step_d;
            pat_rst_q <= (state_d == S_LOAD);
            blank_q   <= (state_d == S_IDLE);
            running_q <= (state_d == S_RUN);
        end
    end

    assign step_en = step_q;
    assign pat_sel = sel_q;
    assign pat_rst = pat_rst_q;
    assign speed   = speed_q;
    assign blank   = blank_q;
    assign running = running_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: directed test of pattern_sequencer with
// DIV_BASE=4, NUM_PATTERNS=4, INIT_SPEED=0, LAPS=2.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_pattern_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_next, btn_pause, btn_speed, pat_done;
    logic       step_en, pat_rst, blank, running;
    logic [1:0] pat_sel, speed;

    int n_checks = 0;
    int n_errors = 0;
    int exp_sel;
    int gap;
    int cnt;
    int rst_cnt;

    pattern_sequencer #(
        .NUM_PATTERNS(4),
        .DIV_BASE    (4),
        .INIT_SPEED  (0),
        .LAPS        (2)
    ) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .btn_next (btn_next),
        .btn_pause(btn_pause),
        .btn_speed(btn_speed),
        .pat_done (pat_done),
        .step_en  (step_en),
        .pat_sel  (pat_sel),
        .pat_rst  (pat_rst),
        .speed    (speed),
        .blank    (blank),
        .running  (running)
    );

    always #5 clk = ~clk;

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One-cycle pulse on the chosen inputs; returns just after the sampling edge.
    task automatic press(input logic nx, input logic pa, input logic sp, input logic pd);
        btn_next  = nx;
        btn_pause = pa;
        btn_speed = sp;
        pat_done  = pd;
        tick(1);
        btn_next  = 1'b0;
        btn_pause = 1'b0;
        btn_speed = 1'b0;
        pat_done  = 1'b0;
    endtask

    // Cycles until the next step_en, bounded at 100.
    task automatic gap_to_step(output int g);
        g = 0;
        do begin
            tick(1);
            g++;
        end while (step_en !== 1'b1 && g < 100);
    endtask

    task automatic count_steps(input int k, output int c);
        c = 0;
        repeat (k) begin
            tick(1);
            if (step_en === 1'b1) c++;
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        btn_next  = 1'b0;
        btn_pause = 1'b0;
        btn_speed = 1'b0;
        pat_done  = 1'b0;
        tick(3);

        // Reset state
        check("rst_step_en", step_en, 0);
        check("rst_pat_sel", pat_sel, 0);
        check("rst_pat_rst", pat_rst, 0);
        check("rst_speed", speed, 0);
        check("rst_blank", blank, 1);
        check("rst_running", running, 0);
        rst_n = 1'b1;
        count_steps(6, cnt);
        check("idle_no_steps", cnt, 0);
        check("idle_blank", blank, 1);

        // 1: start from IDLE, LOAD then steps every 4 cycles
        press(0, 1, 0, 0);
        check("t1_load_pat_rst", pat_rst, 1);
        check("t1_load_blank", blank, 0);
        check("t1_load_pat_sel", pat_sel, 0);
        check("t1_load_step_en", step_en, 0);
        check("t1_load_running", running, 0);
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            check($sformatf("t1_step_c%0d", i), step_en, (i % 4 == 0) ? 1 : 0);
            if (i == 1) begin
                check("t1_running", running, 1);
                check("t1_pat_rst_clear", pat_rst, 0);
            end
        end

        // 2: four btn_next presses spaced 10 cycles
        for (int k = 1; k <= 4; k++) begin
            press(1, 0, 0, 0);
            exp_sel = k % 4;
            check($sformatf("t2_pat_rst_%0d", k), pat_rst, 1);
            check($sformatf("t2_load_step_%0d", k), step_en, 0);
            check($sformatf("t2_pat_sel_%0d", k), pat_sel, exp_sel);
            rst_cnt = 0;
            cnt     = 0;
            repeat (9) begin
                tick(1);
                if (pat_rst === 1'b1) rst_cnt++;
                if (step_en === 1'b1) cnt++;
            end
            check($sformatf("t2_single_rst_%0d", k), rst_cnt, 0);
            check($sformatf("t2_steps_%0d", k), cnt, 2);
        end

        // 3: pause at prescaler=2, resume -> step 2 cycles after the press
        tick(1);
        press(0, 1, 0, 0);
        check("t3_pause_running", running, 0);
        check("t3_pause_blank", blank, 0);
        count_steps(20, cnt);
        check("t3_pause_no_steps", cnt, 0);
        check("t3_pause_held", running, 0);
        press(0, 1, 0, 0);
        check("t3_resume_running", running, 1);
        check("t3_resume_step_c1", step_en, 0);
        tick(1);
        check("t3_resume_step_c2", step_en, 1);
        check("t3_pat_sel", pat_sel, 0);

        // 4: speed steps; a press on the terminal count suppresses that tick
        tick(3);
        press(0, 0, 1, 0);
        check("t4_speed1", speed, 1);
        check("t4_no_step_on_speed", step_en, 0);
        gap_to_step(gap);
        check("t4_gap_speed1", gap, 8);
        gap_to_step(gap);
        check("t4_period_speed1", gap, 8);
        press(0, 0, 1, 0);
        check("t4_speed2", speed, 2);
        gap_to_step(gap);
        check("t4_period_speed2", gap, 16);
        press(0, 0, 1, 0);
        check("t4_speed3", speed, 3);
        gap_to_step(gap);
        check("t4_period_speed3", gap, 32);
        press(0, 0, 1, 0);
        check("t4_speed_wrap", speed, 0);
        gap_to_step(gap);
        check("t4_period_speed0", gap, 4);

        // next + pause together: only the advance happens
        press(1, 1, 0, 0);
        check("t4_combo_pat_rst", pat_rst, 1);
        check("t4_combo_pat_sel", pat_sel, 1);
        // buttons during LOAD are dropped
        press(1, 0, 1, 0);
        check("t4_load_drop_running", running, 1);
        check("t4_load_drop_pat_sel", pat_sel, 1);
        check("t4_load_drop_speed", speed, 0);
        check("t4_load_drop_pat_rst", pat_rst, 0);
        gap_to_step(gap);
        check("t4_first_step_after_load", gap, 3);

        // pause + speed together in RUN: both honoured
        press(0, 1, 1, 0);
        check("t4_pause_speed_running", running, 0);
        check("t4_pause_speed_speed", speed, 1);
        repeat (3) press(0, 0, 1, 0);
        check("t4_pause_speed_wrap", speed, 0);
        // btn_next from PAUSE
        press(1, 0, 0, 0);
        check("t4_pause_next_pat_rst", pat_rst, 1);
        check("t4_pause_next_pat_sel", pat_sel, 2);
        exp_sel = 2;
        tick(1);
        check("t4_pause_next_running", running, 1);

`ifdef AUTO_CYCLE_EN
        // 5: auto-advance after 2 laps
        press(0, 0, 0, 1);
        check("t5_lap1_no_adv", pat_rst, 0);
        check("t5_lap1_pat_sel", pat_sel, 2);
        press(0, 0, 0, 1);
        check("t5_lap2_pat_rst", pat_rst, 1);
        check("t5_lap2_pat_sel", pat_sel, 3);
        tick(1);
        press(0, 0, 0, 1);
        check("t5_lap1b_pat_sel", pat_sel, 3);
        press(0, 1, 0, 0);
        check("t5_pause_running", running, 0);
        press(0, 0, 0, 1);
        check("t5_pause_done_pat_rst", pat_rst, 0);
        check("t5_pause_done_pat_sel", pat_sel, 3);
        press(0, 1, 0, 0);
        check("t5_resume_running", running, 1);
        press(0, 0, 0, 1);
        check("t5_lap2b_pat_rst", pat_rst, 1);
        check("t5_lap2b_pat_sel", pat_sel, 0);
        tick(1);
        press(0, 0, 0, 1);
        check("t5_lap1c_pat_sel", pat_sel, 0);
        press(1, 0, 0, 1);
        check("t5_next_on_lap_pat_rst", pat_rst, 1);
        check("t5_next_on_lap_pat_sel", pat_sel, 1);
        tick(1);
        check("t5_single_adv_pat_rst", pat_rst, 0);
        check("t5_single_adv_pat_sel", pat_sel, 1);
        exp_sel = 1;
`else
        // 5: without auto-cycling, pat_done is ignored
        for (int k = 0; k < 3; k++) begin
            press(0, 0, 0, 1);
            check($sformatf("t5_done_ignored_rst_%0d", k), pat_rst, 0);
            check($sformatf("t5_done_ignored_sel_%0d", k), pat_sel, 2);
        end
`endif

        // 6: reach pat_sel=2, speed=3 in RUN, then a one-cycle reset
        for (int k = 0; k < 4 && exp_sel != 2; k++) begin
            press(1, 0, 0, 0);
            tick(1);
            exp_sel = (exp_sel + 1) % 4;
        end
        repeat (3) press(0, 0, 1, 0);
        tick(5);
        check("t6_pre_pat_sel", pat_sel, 2);
        check("t6_pre_speed", speed, 3);
        check("t6_pre_running", running, 1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("t6_rst_running", running, 0);
        check("t6_rst_blank", blank, 1);
        check("t6_rst_pat_sel", pat_sel, 0);
        check("t6_rst_speed", speed, 0);
        check("t6_rst_pat_rst", pat_rst, 0);
        check("t6_rst_step_en", step_en, 0);
        count_steps(40, cnt);
        check("t6_no_steps", cnt, 0);
        check("t6_still_blank", blank, 1);

        // IDLE: speed alone changes speed; pause+speed starts without the speed change
        press(0, 0, 1, 0);
        check("idle_speed", speed, 1);
        check("idle_speed_blank", blank, 1);
        check("idle_speed_running", running, 0);
        press(0, 1, 1, 0);
        check("idle_start_pat_rst", pat_rst, 1);
        check("idle_start_speed", speed, 1);
        check("idle_start_pat_sel", pat_sel, 0);
        check("idle_start_blank", blank, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
